// File: rtl/ws2812_pkg.sv
// WS2812 shared timing constants, cycle conversion and FSM states.
// Imported by the strip driver and its one-bit encoder.
package ws2812_pkg;

  localparam int T0H_NS  = 400;
  localparam int T1H_NS  = 800;
  localparam int TBIT_NS = 1250;
  localparam int TRST_NS = 60_000;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  // 64-bit intermediate: 50 MHz * 60 us overflows 32 bits.
  function automatic int ns2cyc(
    input longint f_clk,
    input longint ns
  );
    return int'(f_clk / 1000 * ns / 1_000_000);
  endfunction

endpackage

// File: rtl/ws2812_if.sv
// Bit-level handshake between the frame sequencer and the encoder.
// The sequencer starts a bit; the encoder flags its final cycle.
interface ws2812_if;
  logic start;
  logic bit_val;
  logic dat;
  logic bit_done;

  modport master (
    output start,
    output bit_val,
    input  dat,
    input  bit_done
  );

  modport slave (
    input  start,
    input  bit_val,
    output dat,
    output bit_done
  );
endinterface

// File: rtl/ws2812_bit_tx.sv
// WS2812 one-bit NRZ encoder: high for T0H/T1H, low to TBIT.
// bit_done marks the last cycle so the next start follows seamlessly.
module ws2812_bit_tx
  import ws2812_pkg::*;
#(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 62
) (
  input logic     clk,
  input logic     rst_n,
  ws2812_if.slave tx
);

  localparam int BW = $clog2(TBIT + 1);

  logic [BW-1:0] cnt;
  logic [BW-1:0] hi;
  logic          busy;
  logic          dat_q;

  assign tx.dat      = dat_q;
  assign tx.bit_done = busy && (cnt == BW'(TBIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      dat_q <= 1'b0;
    end else if (tx.start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      hi    <= tx.bit_val ? BW'(T1H) : BW'(T0H);
      dat_q <= 1'b1;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if ((cnt + 1'b1) == hi) begin
        dat_q <= 1'b0;
      end
      if (tx.bit_done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ws2812_top.sv
// WS2812 strip driver with a moving-dot demo pattern.
// Frames: TRST latch gap, then NUM_LEDS x 24 GRB bits, repeated.
module ws2812_top
  import ws2812_pkg::*;
#(
  parameter int          F_CLK    = 12_000_000,
  parameter int          NUM_LEDS = 8,
  parameter logic [23:0] COLOR    = 24'h102040
) (
  input  logic clk,
  output logic ws2812_dat,
  output logic ws2812_done,
  output logic ws2812_reset,
  input  logic reset_n
);

  localparam int T0H  = ns2cyc(F_CLK, T0H_NS);
  localparam int T1H  = ns2cyc(F_CLK, T1H_NS);
  localparam int TBIT = ns2cyc(F_CLK, TBIT_NS);
  localparam int TRST = ns2cyc(F_CLK, TRST_NS);
  localparam int CW   = $clog2(TRST + 1);
  localparam int PW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  if (T0H < 1 || T1H < 1 || TBIT < 1 || TRST < 1) begin : g_bad_min
    $error("ws2812_top: timing constant below one cycle");
  end
  if (T1H >= TBIT) begin : g_bad_bit
    $error("ws2812_top: T1H must be shorter than TBIT");
  end

  ws2812_if bus ();

  ws2812_bit_tx #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_bit_tx (
    .clk   (clk),
    .rst_n (reset_n),
    .tx    (bus.slave)
  );

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pix;
  logic [PW-1:0] frame;
  logic [4:0]    bidx;
  logic [23:0]   shreg;

  logic          gap_end;
  logic          bit_end;
  logic          pix_end;
  logic          frm_end;
  logic [PW-1:0] nxt_pix;
  logic [23:0]   nxt_word;

  always_comb begin
    gap_end  = (state == ST_RESET) && (cnt == CW'(TRST - 1));
    bit_end  = (state == ST_SEND) && bus.bit_done;
    pix_end  = bit_end && (bidx == 5'd0);
    frm_end  = pix_end && (pix == PW'(NUM_LEDS - 1));
    nxt_pix  = gap_end ? '0 : pix + 1'b1;
    nxt_word = (nxt_pix == frame) ? COLOR : 24'h000000;
  end

  // Next bit is launched on the edge the current one ends: no gaps.
  assign bus.start   = gap_end || (bit_end && !frm_end);
  assign bus.bit_val = (gap_end || pix_end) ? nxt_word[23]
                                            : shreg[22];
  assign ws2812_dat  = bus.dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_RESET;
      cnt          <= '0;
      pix          <= '0;
      frame        <= '0;
      bidx         <= '0;
      shreg        <= '0;
      ws2812_done  <= 1'b0;
      ws2812_reset <= 1'b1;
    end else begin
      ws2812_done <= 1'b0;
      unique case (state)
        ST_RESET: begin
          if (gap_end) begin
            state        <= ST_SEND;
            ws2812_reset <= 1'b0;
            cnt          <= '0;
            pix          <= '0;
            bidx         <= 5'd23;
            shreg        <= nxt_word;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (frm_end) begin
            state        <= ST_RESET;
            ws2812_done  <= 1'b1;
            ws2812_reset <= 1'b1;
            cnt          <= '0;
            frame        <= (frame == PW'(NUM_LEDS - 1))
                            ? '0 : frame + 1'b1;
          end else if (pix_end) begin
            pix   <= nxt_pix;
            bidx  <= 5'd23;
            shreg <= nxt_word;
          end else if (bit_end) begin
            bidx  <= bidx - 1'b1;
            shreg <= shreg << 1;
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_top.sv
// Bench for ws2812_top: 50 MHz/8 LEDs and 12 MHz/2 LEDs instances
// checked every cycle against a waveform model plus fixed points.
module tb_ws2812_top;

  localparam logic [23:0] COLOR = 24'h102040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  logic dat_a, done_a, rsto_a;
  logic dat_b, done_b, rsto_b;

  int     checks = 0;
  int     errors = 0;
  longint ta = 0;
  longint tb = 0;
  logic   run = 1'b0;

  ws2812_top #(
    .F_CLK    (50_000_000),
    .NUM_LEDS (8),
    .COLOR    (COLOR)
  ) dut_a (
    .clk          (clk),
    .ws2812_dat   (dat_a),
    .ws2812_done  (done_a),
    .ws2812_reset (rsto_a),
    .reset_n      (rst_a)
  );

  ws2812_top #(
    .F_CLK    (12_000_000),
    .NUM_LEDS (2),
    .COLOR    (COLOR)
  ) dut_b (
    .clk          (clk),
    .ws2812_dat   (dat_b),
    .ws2812_done  (done_b),
    .ws2812_reset (rsto_b),
    .reset_n      (rst_b)
  );

  // Clock edges seen since the latest reset release.
  always @(posedge clk or negedge rst_a)
    if (!rst_a) ta <= 0;
    else        ta <= ta + 1;

  always @(posedge clk or negedge rst_b)
    if (!rst_b) tb <= 0;
    else        tb <= tb + 1;

  // Expected {dat, done, reset} after t edges, from the frame rules.
  function automatic logic [2:0] model(
    input longint t,
    input longint trst,
    input longint tbit,
    input longint t0h,
    input longint t1h,
    input longint n
  );
    longint p, f, ph, q, k, pix, w;
    int bp;
    logic [23:0] val;
    logic b, dn;
    p  = trst + n * 24 * tbit;
    f  = t / p;
    ph = t % p;
    dn = (t > 0) && (ph == 0);
    if (ph < trst) return {1'b0, dn, 1'b1};
    q   = ph - trst;
    k   = q / tbit;
    pix = k / 24;
    bp  = 23 - int'(k % 24);
    w   = q % tbit;
    val = (pix == f % n) ? COLOR : 24'h000000;
    b   = val[bp];
    return {(w < (b ? t1h : t0h)), 1'b0, 1'b0};
  endfunction

  task automatic check(
    input string      name,
    input longint     t,
    input logic [2:0] got,
    input logic [2:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%b expected=%b",
               name, t, got, exp);
    end
  endtask

  longint     lit_a_t [18] = '{
    2999, 3000, 3019, 3020, 3061, 3062, 3185, 3186, 3225,
    3226, 3248, 14903, 14904, 14905, 18109, 18110, 19617, 19618
  };
  logic [2:0] lit_a_v [18] = '{
    3'b001, 3'b100, 3'b100, 3'b000, 3'b000, 3'b100,
    3'b000, 3'b100, 3'b100, 3'b000, 3'b100, 3'b000,
    3'b011, 3'b001, 3'b100, 3'b000, 3'b100, 3'b000
  };
  longint     lit_b_t [16] = '{
    719, 720, 723, 724, 734, 735, 773, 774,
    779, 780, 1440, 1441, 2208, 2209, 3653, 3654
  };
  logic [2:0] lit_b_v [16] = '{
    3'b001, 3'b100, 3'b100, 3'b000, 3'b000, 3'b100,
    3'b100, 3'b000, 3'b000, 3'b100, 3'b011, 3'b001,
    3'b100, 3'b000, 3'b100, 3'b000
  };

  always @(negedge clk) begin
    if (run) begin
      logic [2:0] ea, eb;
      ea = model(ta, 3000, 62, 20, 40, 8);
      eb = model(tb, 720, 15, 4, 9, 2);
      check("model_a", ta, {dat_a, done_a, rsto_a}, ea);
      check("model_b", tb, {dat_b, done_b, rsto_b}, eb);
      foreach (lit_a_t[i]) begin
        if (ta == lit_a_t[i]) begin
          check("lit_a", ta, {dat_a, done_a, rsto_a}, lit_a_v[i]);
          check("pin_a", ta, ea, lit_a_v[i]);
        end
      end
      foreach (lit_b_t[i]) begin
        if (tb == lit_b_t[i]) begin
          check("lit_b", tb, {dat_b, done_b, rsto_b}, lit_b_v[i]);
          check("pin_b", tb, eb, lit_b_v[i]);
        end
      end
    end
  end

  task automatic wait_a(input longint target, input int budget);
    int n;
    n = 0;
    while (ta < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ta != target) begin
      errors++;
      $display("FAIL wait_a timeout t=%0d wanted=%0d", ta, target);
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    run   = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Frame 1, pixel 3, bit 5, 5 cycles in: line is high here.
    wait_a(22683, 30000);
    #1;
    check("pre_rst", ta, {dat_a, done_a, rsto_a}, 3'b100);
    rst_a = 1'b0;
    #1;
    check("async_rst", ta, {dat_a, done_a, rsto_a}, 3'b001);
    repeat (5) @(posedge clk);
    #2;
    rst_a = 1'b1;

    wait_a(3 * 14904 + 10, 50000);

    checks++;
    if (tb < 3700) begin
      errors++;
      $display("FAIL run_b_length got=%0d expected>=3700", tb);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_top.md
# ws2812_top

Self-contained WS2812 (NeoPixel) strip driver and demo pattern generator; the design's top level. The block serialises a fixed-length chain of 24-bit GRB pixels onto a single one-wire data pin using the WS2812 NRZ bit encoding. It then holds the line low for the latch (reset) interval and repeats. Each frame advances a "moving dot" pattern by one LED. All timing is derived from the clock-frequency parameter.

## Interface
- `F_CLK`, default 12_000_000: clock frequency in Hz; all pulse widths derive from it.
- `NUM_LEDS`, default 8: number of pixels per frame.
- `COLOR`, default 24'h102040: GRB value of the lit pixel (G=0x10, R=0x20, B=0x40).
- `clk` input 1: system clock.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `ws2812_dat` output 1: serial data to the strip.
- `ws2812_done` output 1: one-cycle pulse when the last bit of a frame completes.
- `ws2812_reset` output 1: high while the latch/reset gap is being driven.
- Port order: `clk`, `ws2812_dat`, `ws2812_done`, `ws2812_reset`, `reset_n`. `reset_n` is last so that 4-port positional instantiations still bind. Tie `reset_n` high when unused.

## Operation
- Cycle constants, integer-truncated as cycles = F_CLK/1000 * ns / 1_000_000:
  - T0H = 400 ns
  - T1H = 800 ns
  - TBIT = 1250 ns
  - TRST = 60_000 ns
- At 50 MHz these give T0H=20, T1H=40, TBIT=62, TRST=3000.
- At 12 MHz these give T0H=4, T1H=9, TBIT=15, TRST=720.
- State machine: RESET -> SEND -> RESET …
- RESET:
  - `ws2812_dat`=0 and `ws2812_reset`=1 for TRST cycles.
  - Then clear the pixel and bit indices and go to SEND.
- SEND, per bit:
  - `ws2812_dat`=1 for T0H cycles (bit 0) or T1H cycles (bit 1).
  - Then 0 for the remainder of TBIT.
- Bit order: pixel 0 first; within a pixel, MSB first (G7…G0, R7…R0, B7…B0).
- Pixel value: COLOR if pixel index == frame counter, else 24'h000000.
- After bit 0 of pixel NUM_LEDS-1 finishes its TBIT:
  - Assert `ws2812_done` for exactly one cycle.
  - Frame counter increments, wrapping from NUM_LEDS-1 to 0.
  - Enter RESET.
- Pixel data is latched into a 24-bit shift register at the start of each pixel. Pattern changes only take effect between frames.

## Timing
- Reset values while `reset_n`=0:
  - `ws2812_dat`=0, `ws2812_done`=0, `ws2812_reset`=1.
  - State=RESET, all counters=0, frame counter=0.
- The first cycle after `reset_n` rises is cycle 1 of the TRST gap.
- The first rising edge of `ws2812_dat` occurs exactly TRST cycles after reset release.
- Frame data duration = NUM_LEDS*24*TBIT cycles, with no gaps between bits or pixels.
- `ws2812_done` is registered and asserts on the same cycle `ws2812_reset` goes high.
- Assertion of `reset_n` mid-bit forces `ws2812_dat` low immediately (asynchronous) and restarts at frame 0.
- Constants must be at least 1. If T1H >= TBIT, the constant derivation is invalid and simulation must `$error`.

## Structure
- Shared package `ws2812_pkg` holds:
  - the ns timing constants;
  - a function converting (F_CLK, ns) to cycles;
  - the state enum.
- Sub-module `ws2812_bit_tx`: one-bit encoder.
  - Inputs: `start`, `bit`.
  - Outputs: `dat`, `bit_done`.
  - Instantiated once inside the top.
- The top holds the frame/pixel/bit counters, the pattern generator, the shift register and the RESET/SEND FSM.

## Test plan
1. F_CLK=50 MHz, NUM_LEDS=8, reset pulse of 100 ns:
   - `ws2812_reset`=1 and `ws2812_dat`=0 for 3000 cycles.
   - Then the first bit (G7=0) gives `dat` high 20 cycles, low 42 cycles.
2. Same config: frame 0 bit 3 (G4=1) gives `dat` high 40 cycles, low 22 cycles. Pixels 1–7 produce only 20/42 zero pulses.
3. Same config: `ws2812_done` single-cycle pulse at cycle 3000+11904 after reset release. `ws2812_reset` rises on the same cycle.
4. Frame 1: pixel 0 all zeros, pixel 1 = 0x102040. Frame 8 wraps back to pixel 0 lit. Check three frames within 1 ms at 50 MHz.
5. Assert `reset_n` mid-pixel 3 of frame 1:
   - `dat` drops to 0 asynchronously and `ws2812_reset`=1.
   - After release, a full 3000-cycle gap, then frame 0 pattern.
6. F_CLK=12 MHz: zero bit = 4 high / 11 low, one bit = 9 high / 6 low, gap = 720 cycles.
